writeback_stage: RTL

Final pipeline stage, directly downstream of the memory stage. It accepts one retired instruction per cycle over the prev_done/stall_prev handshake and drives the register-file write port, with x0 writes suppressed. The same write port is exposed as a bypass source for earlier stages. It halts the pipeline on an environment call or an illegal opcode, and optionally counts retired instructions.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/retire_counter.sv | 18 +
 rtl/writeback_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, opcode-flag struct and writeback state for the pipeline
package pipeline_pkg;

  localparam int ADDR_WIDTH              = 32;
  localparam int DATA_WIDTH              = 32;
  localparam int NUM_REGISTERS           = 32;
  localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);

  typedef struct packed {
    logic load;
    logic store;
    logic environment;
    logic opcode_legal;
    logic register_arith;
    logic immediate_arith;
    logic branch;
    logic immediate_jump;
    logic register_jump;
    logic load_upper;
    logic load_upper_pc;
  } opcode_flags_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    WRITE  = 2'd1,
    HALTED = 2'd2
  } wb_state_t;

  // An environment call or an unrecognised opcode stops the pipeline for good.
  function automatic logic entry_halts(input opcode_flags_t flags);
    return flags.environment || !flags.opcode_legal;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - 64-bit retired-instruction counter with synchronous clear
module retire_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [63:0] count
);

  // Natural binary wrap from all-ones back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final pipeline stage driving the register-file write port and halt
// Optional retired-instruction counter enabled by defining RETIRE_COUNTER_EN.
module writeback_stage #(
  parameter int ADDR_WIDTH              = pipeline_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH              = pipeline_pkg::DATA_WIDTH,
  parameter int NUM_REGISTERS           = pipeline_pkg::NUM_REGISTERS,
  parameter int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               prev_done,
  output logic                               stall_prev,
  input  logic [ADDR_WIDTH-1:0]              program_count_in,
  input  logic                               program_count_valid_in,
  input  logic                               load_in,
  input  logic                               store_in,
  input  logic                               environment_in,
  input  logic                               opcode_legal_in,
  input  logic                               register_arith_in,
  input  logic                               immediate_arith_in,
  input  logic                               branch_in,
  input  logic                               immediate_jump_in,
  input  logic                               register_jump_in,
  input  logic                               load_upper_in,
  input  logic                               load_upper_pc_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  input  logic                               write_register_valid_in,
  input  logic [DATA_WIDTH-1:0]              result_data_in,
  input  logic                               result_data_valid_in,
  output logic                               reg_write_enable,
  output logic [REGISTER_INDEXING_WIDTH-1:0] reg_write_index,
  output logic [DATA_WIDTH-1:0]              reg_write_data,
  output logic                               halted,
  output logic [ADDR_WIDTH-1:0]              halt_pc
`ifdef RETIRE_COUNTER_EN
  ,
  output logic [63:0]                        retired_count
`endif
);

  import pipeline_pkg::*;

  wb_state_t                        state;
  opcode_flags_t                    flags_in;
  opcode_flags_t                    flags_q;
  logic [ADDR_WIDTH-1:0]            pc_q;
  logic [REGISTER_INDEXING_WIDTH-1:0] wr_idx_q;
  logic                             wr_idx_valid_q;
  logic [DATA_WIDTH-1:0]            data_q;
  logic                             data_valid_q;
  logic                             transfer_prev;
  logic                             halting;
  logic                             load_entry;

  assign flags_in = '{
    load:            load_in,
    store:           store_in,
    environment:     environment_in,
    opcode_legal:    opcode_legal_in,
    register_arith:  register_arith_in,
    immediate_arith: immediate_arith_in,
    branch:          branch_in,
    immediate_jump:  immediate_jump_in,
    register_jump:   register_jump_in,
    load_upper:      load_upper_in,
    load_upper_pc:   load_upper_pc_in
  };

  assign stall_prev    = rst || (state == HALTED);
  assign transfer_prev = prev_done && !stall_prev;
  assign halting       = (state == WRITE) && entry_halts(flags_q);

  // An entry taken alongside a halting WRITE is dropped, so the held entry (and
  // with it the visible write index/data) stays on the last real instruction.
  assign load_entry = transfer_prev && ((state == EMPTY) || ((state == WRITE) && !halting));

  assign reg_write_enable = (state == WRITE) && wr_idx_valid_q && data_valid_q &&
                            (wr_idx_q != '0) && flags_q.opcode_legal && !flags_q.environment;
  assign reg_write_index  = wr_idx_q;
  assign reg_write_data   = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      halted  <= 1'b0;
      halt_pc <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (transfer_prev) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (halting) begin
            state   <= HALTED;
            halted  <= 1'b1;
            halt_pc <= pc_q;
          end else if (!transfer_prev) begin
            state <= EMPTY;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q        <= '0;
      pc_q           <= '0;
      wr_idx_q       <= '0;
      wr_idx_valid_q <= 1'b0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
    end else if (load_entry) begin
      flags_q        <= flags_in;
      pc_q           <= program_count_in;
      wr_idx_q       <= write_register_in;
      wr_idx_valid_q <= write_register_valid_in;
      data_q         <= result_data_in;
      data_valid_q   <= result_data_valid_in;
    end
  end

  // Opcode classes other than halt/legality travel with the entry but steer nothing here.
  logic unused_flags;
  assign unused_flags = ^{program_count_valid_in, flags_q.load, flags_q.store,
                          flags_q.register_arith, flags_q.immediate_arith, flags_q.branch,
                          flags_q.immediate_jump, flags_q.register_jump, flags_q.load_upper,
                          flags_q.load_upper_pc};

`ifdef RETIRE_COUNTER_EN
  logic retire_inc;

  // Environment calls retire before halting; illegal opcodes never retire.
  assign retire_inc = (state == WRITE) && flags_q.opcode_legal;

  retire_counter u_retire_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire_inc),
    .count (retired_count)
  );
`else
  // Without the counter, retirement is visible only through the write port.
`endif

endmodule
